// File: rtl/cpu_defs.sv
// cpu_defs: shared constants and fetch FSM encoding for the MIPS pipeline front end.
package cpu_defs;
    localparam int          PC_W_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] NOP          = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;
endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry F-stage buffer plus a shadow slot for a fetch that completes under stall.
module fetch_skid_buf
    import cpu_defs::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         stall,
    input  logic         flush_shadow,
    input  logic         in_valid,
    input  logic [W-1:0] in_pc,
    input  logic [W-1:0] in_instr,
    input  logic         in_adel,
    output logic         buf_valid,
    output logic [W-1:0] buf_pc,
    output logic [W-1:0] buf_instr,
    output logic         buf_adel
);
    logic         sh_valid;
    logic [W-1:0] sh_pc;
    logic [W-1:0] sh_instr;
    logic         sh_adel;
    logic         to_shadow;
    logic         from_shadow;
    logic         load;

    assign to_shadow   = in_valid & buf_valid & stall;
    assign from_shadow = sh_valid & !stall & !flush_shadow;
    assign load        = (in_valid & !to_shadow) | from_shadow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid <= 1'b0;
            buf_pc    <= '0;
            buf_instr <= W'(NOP);
            buf_adel  <= 1'b0;
            sh_valid  <= 1'b0;
            sh_pc     <= '0;
            sh_instr  <= W'(NOP);
            sh_adel   <= 1'b0;
        end else begin
            if (load) begin
                buf_valid <= 1'b1;
                buf_pc    <= from_shadow ? sh_pc : in_pc;
                buf_instr <= from_shadow ? sh_instr : in_instr;
                buf_adel  <= from_shadow ? sh_adel : in_adel;
            end else if (!stall) begin
                buf_valid <= 1'b0;
            end
            if (to_shadow) begin
                sh_valid <= 1'b1;
                sh_pc    <= in_pc;
                sh_instr <= in_instr;
                sh_adel  <= in_adel;
            end else if (!stall) begin
                sh_valid <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/fetch_pc_sequencer.sv
// fetch_pc_sequencer: fetch PC owner with imem req/ack, delay-slot redirect and stall handling.
module fetch_pc_sequencer
    import cpu_defs::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            redirect_valid_i,
    input  logic [PC_W-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [PC_W-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [PC_W-1:0] imem_rdata_i,
    output logic            f_valid_o,
    output logic [PC_W-1:0] f_pc_o,
    output logic [PC_W-1:0] f_instr_o,
    output logic            f_adel_o
);
    fetch_state_t    state_q;
    fetch_state_t    state_d;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pend_pc_q;
    logic [PC_W-1:0] sq_addr_q;
    logic [PC_W-1:0] fetch_pc;
    logic            pend_q;
    logic            squash_q;
    logic            ack_req;
    logic            redir;
    logic            redir_a;
    logic            redir_b;
    logic            accept;

    assign ack_req = (state_q == REQ) & imem_ack_i;
    assign redir   = redirect_valid_i & !stall_i;
    assign redir_a = redir & f_valid_o;
    assign redir_b = redir & !f_valid_o;
    assign accept  = ack_req & !squash_q & !redir_a;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= BOOT;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = REQ;
            REQ:     state_d = (imem_ack_i & f_valid_o & stall_i) ? HOLD : REQ;
            HOLD:    state_d = stall_i ? HOLD : REQ;
            default: state_d = BOOT;
        endcase
    end

    // While a squashed request is still outstanding its original address stays on the bus.
    always_comb begin
        fetch_pc    = squash_q ? sq_addr_q : pc_q;
        imem_req_o  = (state_q == REQ);
        imem_addr_o = {fetch_pc[PC_W-1:2], 2'b00};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
            squash_q  <= 1'b0;
            sq_addr_q <= '0;
        end else begin
            if (ack_req & squash_q) squash_q <= 1'b0;
            if (accept) begin
                pc_q   <= redir_b ? redirect_pc_i : pend_q ? pend_pc_q : pc_q + PC_W'(4);
                pend_q <= 1'b0;
            end else if (redir_b) begin
                pend_q    <= 1'b1;
                pend_pc_q <= redirect_pc_i;
            end
            if (redir_a) begin
                pc_q <= redirect_pc_i;
                if (imem_req_o & !imem_ack_i) begin
                    squash_q  <= 1'b1;
                    sq_addr_q <= pc_q;
                end
            end
        end
    end

    fetch_skid_buf #(.W(PC_W)) u_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall_i),
        .flush_shadow (redir_a),
        .in_valid     (accept),
        .in_pc        (pc_q),
        .in_instr     (imem_rdata_i),
        .in_adel      (|pc_q[1:0]),
        .buf_valid    (f_valid_o),
        .buf_pc       (f_pc_o),
        .buf_instr    (f_instr_o),
        .buf_adel     (f_adel_o)
    );
endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// tb_fetch_pc_sequencer: directed and random stimulus against an instruction-stream reference model.
module tb_fetch_pc_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_i = 1'b0;
    logic        redirect_valid_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        f_valid_o;
    logic [31:0] f_pc_o;
    logic [31:0] f_instr_o;
    logic        f_adel_o;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_tgt;
    bit          exp_pend;
    int          lat_min, lat_max, mem_cnt, mem_lat;
    bit          boot_ack;
    bit          was_busy;
    logic [31:0] busy_addr;
    int          idle;
    int          deliveries;

    fetch_pc_sequencer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall_i          (stall_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_req_o       (imem_req_o),
        .imem_addr_o      (imem_addr_o),
        .imem_ack_i       (imem_ack_i),
        .imem_rdata_i     (imem_rdata_i),
        .f_valid_o        (f_valid_o),
        .f_pc_o           (f_pc_o),
        .f_instr_o        (f_instr_o),
        .f_adel_o         (f_adel_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic model_reset();
        exp_pc   = 32'h0000_3000;
        exp_pend = 1'b0;
        mem_cnt  = 0;
        mem_lat  = lat_min;
        was_busy = 1'b0;
        idle     = 0;
    endtask

    // One cycle: protocol checks, drive inputs, memory response, stream model, advance to next negedge.
    task automatic step(input bit st, input bit rv, input logic [31:0] rpc);
        if (was_busy) begin
            check("req_held", imem_req_o, 1);
            check("addr_stable", imem_addr_o, busy_addr);
        end
        stall_i          = st;
        redirect_valid_i = rv;
        redirect_pc_i    = rpc;
        imem_ack_i       = 1'b0;
        imem_rdata_i     = 32'hDEAD_BEEF;
        if (boot_ack) begin
            imem_ack_i = 1'b1;
            boot_ack   = 1'b0;
        end else if (imem_req_o) begin
            if (mem_cnt >= mem_lat) begin
                imem_ack_i   = 1'b1;
                imem_rdata_i = mem_word(imem_addr_o);
                mem_cnt      = 0;
                mem_lat      = $urandom_range(lat_max, lat_min);
            end else begin
                mem_cnt++;
            end
        end
        if (f_valid_o && !st) begin
            check("f_pc", f_pc_o, exp_pc);
            check("f_instr", f_instr_o, mem_word({exp_pc[31:2], 2'b00}));
            check("f_adel", f_adel_o, exp_pc[1:0] != 2'b00);
            deliveries++;
            idle     = 0;
            exp_pc   = rv ? rpc : exp_pend ? exp_tgt : exp_pc + 32'd4;
            exp_pend = 1'b0;
        end else if (rv && !st) begin
            exp_pend = 1'b1;
            exp_tgt  = rpc;
        end else begin
            idle++;
        end
        if (idle > 80) begin
            check("stream_progress", idle, 80);
            idle = 0;
        end
        was_busy  = imem_req_o && !imem_ack_i;
        busy_addr = imem_addr_o;
        @(negedge clk);
    endtask

    task automatic next_valid(input string tag, input logic [31:0] want);
        int n = 0;
        while (!f_valid_o && n < 40) begin
            step(1'b0, 1'b0, '0);
            n++;
        end
        check({tag, "_timeout"}, f_valid_o, 1);
        check(tag, f_pc_o, want);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int n;
        logic [31:0] held;
        lat_min = 0;
        lat_max = 0;
        boot_ack = 1'b0;
        deliveries = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_req", imem_req_o, 0);
        check("rst_addr", imem_addr_o, 32'h0000_3000);
        check("rst_valid", f_valid_o, 0);
        check("rst_pc", f_pc_o, 0);
        check("rst_instr", f_instr_o, 0);
        check("rst_adel", f_adel_o, 0);
        rst_n = 1'b1;
        check("boot_req", imem_req_o, 0);
        step(1'b0, 1'b0, '0);
        check("first_req", imem_req_o, 1);
        check("first_addr", imem_addr_o, 32'h0000_3000);
        step(1'b0, 1'b0, '0);
        check("first_valid", f_valid_o, 1);
        check("pc0", f_pc_o, 32'h0000_3000);
        step(1'b0, 1'b0, '0);
        check("pc1", f_pc_o, 32'h0000_3004);
        step(1'b0, 1'b0, '0);
        check("pc2", f_pc_o, 32'h0000_3008);
        step(1'b0, 1'b1, 32'h0000_3100);
        check("discard_gap", f_valid_o, 0);
        step(1'b0, 1'b0, '0);
        check("tgt0", f_pc_o, 32'h0000_3100);
        step(1'b0, 1'b0, '0);
        check("tgt1", f_pc_o, 32'h0000_3104);
        step(1'b0, 1'b1, 32'h0000_3102);
        check("mis_addr", imem_addr_o, 32'h0000_3100);
        step(1'b0, 1'b0, '0);
        check("mis_pc", f_pc_o, 32'h0000_3102);
        check("mis_adel", f_adel_o, 1);
        held = f_instr_o;
        repeat (5) begin
            step(1'b1, 1'b0, '0);
            check("stall_hold", f_instr_o, held);
        end
        step(1'b0, 1'b0, '0);
        check("after_stall", f_pc_o, 32'h0000_3106);
        step(1'b0, 1'b1, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, '0);
        check("wrap0", f_pc_o, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, '0);
        check("wrap1", f_pc_o, 32'h0000_0000);
        lat_min = 3;
        lat_max = 3;
        mem_lat = 3;
        n = 0;
        repeat (16) begin
            step(1'b0, 1'b0, '0);
            n += int'(f_valid_o);
        end
        check("lat3_rate", n, 4);
        check("lat3_pc", f_pc_o, 32'h0000_0010);
        step(1'b0, 1'b1, 32'h0000_5000);
        check("squash_addr", imem_addr_o, 32'h0000_0014);
        next_valid("squash_tgt", 32'h0000_5000);
        step(1'b0, 1'b0, '0);
        check("b_gap", f_valid_o, 0);
        step(1'b0, 1'b1, 32'h0000_4000);
        next_valid("delay_slot", 32'h0000_5004);
        step(1'b0, 1'b0, '0);
        next_valid("b_tgt", 32'h0000_4000);
        step(1'b0, 1'b0, '0);
        check("mid_req", imem_req_o, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_req", imem_req_o, 0);
        check("arst_addr", imem_addr_o, 32'h0000_3000);
        check("arst_valid", f_valid_o, 0);
        check("arst_pc", f_pc_o, 0);
        check("arst_instr", f_instr_o, 0);
        check("arst_adel", f_adel_o, 0);
        @(negedge clk);
        lat_min = 0;
        lat_max = 0;
        model_reset();
        boot_ack = 1'b1;
        rst_n = 1'b1;
        check("reboot_req", imem_req_o, 0);
        step(1'b0, 1'b0, '0);
        next_valid("restart", 32'h0000_3000);
        lat_max = 3;
        n = deliveries;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rpc;
            rpc = 32'h0000_3000 + ($urandom_range(0, 1023) << 2);
            if ($urandom_range(0, 9) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
            step($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 8, rpc);
        end
        check("random_progress", deliveries - n > 500, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_pc_sequencer.md
Name: fetch_pc_sequencer

Overview:
Owns the architectural fetch PC of the 5-stage MIPS pipeline. It issues word requests to instruction memory over a req/ack handshake and holds a one-entry F-stage output buffer in front of the F/D register. It applies the D-stage next-PC redirect (branch/jump target) with MIPS delay-slot semantics, and obeys the hazard-unit stall.

Parameters:
RESET_PC, 32'h0000_3000, PC loaded on reset; first fetch address.
PC_W, 32, PC/address/data width.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
stall_i  in  1  hazard freeze of F/D; buffered instruction must not advance
redirect_valid_i  in  1  D-stage control-flow instruction resolved taken/jump this cycle
redirect_pc_i  in  32  next-PC target from D-stage next-PC logic
imem_req_o  out  1  fetch request; held until ack
imem_addr_o  out  32  word address {pc_q[31:2],2'b00}; stable while req high
imem_ack_i  in  1  read data valid, completes the request
imem_rdata_i  in  32  instruction word
f_valid_o  out  1  buffer holds an instruction
f_pc_o  out  32  PC of buffered instruction
f_instr_o  out  32  buffered instruction
f_adel_o  out  1  buffered instruction's PC was misaligned (pc[1:0]!=0)

Behaviour:
- Reset (async, any state): pc_q=RESET_PC, state=BOOT, buf_valid=0, f_pc_o=0, f_instr_o=0, f_adel_o=0, imem_req_o=0, pend_q=0, pend_pc_q=0, squash_q=0.
- FSM:
  - BOOT: req=0 for exactly one cycle after rst_n rises; any ack is ignored; next state REQ.
  - REQ: req=1, addr=pc_q.
  - HOLD: req=0.
- REQ -> HOLD when buf_valid & stall_i and no request is in flight. HOLD -> REQ when !stall_i.
- A request, once raised, is never withdrawn before ack, even if stall rises.
- Buffer load: on ack in REQ with squash_q=0 and (buf_valid=0 | stall_i=0):
  - buffer <= {pc_q, rdata, pc_q[1:0]!=0}.
  - pc_q <= pend_q ? pend_pc_q : pc_q+4 (mod 2^32, wrap allowed).
  - pend_q <= 0.
- Ack while buf_valid & stall_i: the word is held in a shadow register and loaded the cycle stall drops. No request is issued meanwhile.
- Consume: buffer empties when !stall_i and no load the same cycle. The buffer is never overwritten while stall_i=1.
- Latency: with ack in the same cycle as req and no stall, one instruction per cycle. The first f_valid_o appears 2 cycles after rst_n release with zero-wait memory.
- Redirect is accepted only when redirect_valid_i & !stall_i.
  - Case A, f_valid_o=1 (delay slot advances now):
    - pc_q <= redirect_pc_i.
    - An ack in the same cycle is discarded, with no buffer load and no pc increment.
    - An outstanding unacked request sets squash_q; the next ack is discarded and clears squash_q; the FSM then re-requests from the redirected pc_q.
  - Case B, f_valid_o=0 (delay slot not yet delivered):
    - pend_q<=1, pend_pc_q<=redirect_pc_i. The next non-squashed load is the delay slot and then switches pc_q to the target.
    - If the load occurs in the same cycle as the redirect, it is the delay slot and pc_q <= redirect_pc_i directly.
  - Redirect while pend_q=1 (branch in delay slot, ISA-undefined): overwrites pend_pc_q. Deterministic, no error.
- Misaligned target: fetched with the low bits cleared; f_adel_o=1 travels with the instruction. The sequencer does no exception redirect itself.
- Reset mid-request: the request is abandoned. Memory must tolerate it; a stale ack during BOOT is ignored.

Decomposition:
- Shared package cpu_defs: RESET_PC value, FSM state encoding (BOOT/REQ/HOLD, 2 bits), NOP word 32'h0000_0000.
- One natural sub-module: fetch_skid_buf, the one-entry buffer plus shadow register with load/consume/hold logic. The FSM, PC, pending and squash logic stay in the top.

Test Plan:
- Reset, zero-wait memory, no stall -> f_pc_o sequence 0x3000, 0x3004, 0x3008 on consecutive cycles; imem_req_o=0 in the BOOT cycle.
- Ack latency 3 cycles -> imem_addr_o stable over the wait; one f_valid_o per 4 cycles; pc increments by 4.
- Branch in D at f_pc_o=0x3008 (delay slot valid), redirect_pc=0x3100, fetch of 0x300C outstanding -> 0x300C ack discarded; next f_pc_o values are 0x3100, 0x3104.
- Redirect 0x4000 while f_valid_o=0, delay slot 0x3010 in flight -> f_pc_o 0x3010 delivered, then 0x4000.
- stall_i held 5 cycles with a full buffer and ack arriving during the stall -> f_instr_o unchanged throughout; the held word appears the cycle after stall drops; no duplicate or lost PC.
- Redirect to 0x3102 -> imem_addr_o=0x3100, f_adel_o=1 with f_pc_o=0x3102. Separately, rst_n pulsed low mid-request -> all outputs at reset values immediately, fetch restarts at 0x3000.
